// File: rtl/uart_tx_framer_if.sv
// Producer-to-framer bus for the UART transmit framer.
// master: producer side, drives tx_valid/tx_data and observes line + status.
// slave:  framer side, samples tx_valid/tx_data and drives tx_ready, tx and status flags.
interface uart_tx_framer_if #(
  parameter int DATA_W = 8
);
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              tx;
  logic              busy;
  logic              start;
  logic              datastate;
  logic              parity;
  logic              frame_done;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, tx, busy, start, datastate, parity, frame_done
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, tx, busy, start, datastate, parity, frame_done
  );
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmit framer: START, DATA_W data bits LSB first, optional parity, 1..2 STOP bits.
// Latency: tx drops to 0 the cycle after accept; frame = (1+DATA_W+P+STOP_BITS)*CLKS_PER_BIT clk.
// Backpressure: tx_ready high only in IDLE; words offered while busy are ignored, not queued.
// Ports: clk_i, reset_i (sync, active-high); bus (slave modport) carries tx_valid/tx_data in,
//   tx_ready, tx, busy, start, datastate, parity, frame_done out -- all outputs registered.
module uart_tx_framer #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  uart_tx_framer_if.slave bus
);

  // Mode 3 is treated as "no parity".
  localparam bit PAR_EN = (PARITY_MODE == 1) || (PARITY_MODE == 2);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_q, par_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                start_q, start_d;
  logic                data_q, data_d;
  logic                parf_q, parf_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                baud_end;

  assign baud_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_end ? '0 : baud_q + BAUD_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (bus.tx_valid && ready_q) begin
          state_d = S_START;
          shift_d = bus.tx_data;
          par_d   = (PARITY_MODE == 2) ? ~(^bus.tx_data) : ^bus.tx_data;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        // Shift at the end of every data bit so shift_q[0] is always the bit on the line.
        if (baud_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            bit_d   = '0;
            state_d = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (baud_end) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            state_d = S_IDLE;
            bit_d   = '0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase

    // Line and flags are decoded from the next state so they register together with it.
    tx_d    = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
    start_d = (state_d == S_START);
    data_d  = (state_d == S_DATA);
    parf_d  = (state_d == S_PARITY);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      data_q  <= 1'b0;
      parf_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      data_q  <= data_d;
      parf_q  <= parf_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.start      = start_q;
  assign bus.datastate  = data_q;
  assign bus.parity     = parf_q;
  assign bus.tx_ready   = ready_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: three configurations share clock and reset.
//   0: DATA_W=8, 16 clk/bit, even parity, 1 stop
//   1: DATA_W=8,  4 clk/bit, odd parity,  1 stop
//   2: DATA_W=7, 16 clk/bit, no parity,   2 stop
module tb_uart_tx_framer;
  localparam int DW  [3] = '{8, 8, 7};
  localparam int CPB [3] = '{16, 4, 16};
  localparam int PM  [3] = '{1, 2, 0};
  localparam int SB  [3] = '{1, 1, 2};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid_r [3];
  logic [8:0] data_r  [3];
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  uart_tx_framer_if #(.DATA_W(DW[0])) if0 ();
  uart_tx_framer_if #(.DATA_W(DW[1])) if1 ();
  uart_tx_framer_if #(.DATA_W(DW[2])) if2 ();

  uart_tx_framer #(.DATA_W(DW[0]), .CLKS_PER_BIT(CPB[0]), .PARITY_MODE(PM[0]), .STOP_BITS(SB[0]))
    u0 (.clk_i(clk), .reset_i(reset), .bus(if0.slave));
  uart_tx_framer #(.DATA_W(DW[1]), .CLKS_PER_BIT(CPB[1]), .PARITY_MODE(PM[1]), .STOP_BITS(SB[1]))
    u1 (.clk_i(clk), .reset_i(reset), .bus(if1.slave));
  uart_tx_framer #(.DATA_W(DW[2]), .CLKS_PER_BIT(CPB[2]), .PARITY_MODE(PM[2]), .STOP_BITS(SB[2]))
    u2 (.clk_i(clk), .reset_i(reset), .bus(if2.slave));

  assign if0.tx_valid = valid_r[0];
  assign if1.tx_valid = valid_r[1];
  assign if2.tx_valid = valid_r[2];
  assign if0.tx_data  = data_r[0][7:0];
  assign if1.tx_data  = data_r[1][7:0];
  assign if2.tx_data  = data_r[2][6:0];

  logic tx_s [3], busy_s [3], rdy_s [3], st_s [3], dat_s [3], par_s [3], fd_s [3];
  assign tx_s[0] = if0.tx;         assign tx_s[1] = if1.tx;         assign tx_s[2] = if2.tx;
  assign busy_s[0] = if0.busy;     assign busy_s[1] = if1.busy;     assign busy_s[2] = if2.busy;
  assign rdy_s[0] = if0.tx_ready;  assign rdy_s[1] = if1.tx_ready;  assign rdy_s[2] = if2.tx_ready;
  assign st_s[0] = if0.start;      assign st_s[1] = if1.start;      assign st_s[2] = if2.start;
  assign dat_s[0] = if0.datastate; assign dat_s[1] = if1.datastate; assign dat_s[2] = if2.datastate;
  assign par_s[0] = if0.parity;    assign par_s[1] = if1.parity;    assign par_s[2] = if2.parity;
  assign fd_s[0] = if0.frame_done; assign fd_s[1] = if1.frame_done; assign fd_s[2] = if2.frame_done;

  // Offer a word from just after a posedge; returns right after the accepting posedge.
  task automatic send_start(input int sel, input logic [8:0] d, input bit hold);
    bit ok;
    @(posedge clk); #1;
    data_r[sel]  = d;
    valid_r[sel] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rdy_s[sel] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout dut%0d: tx_ready never rose within 1000 clk", sel);
    end
    @(posedge clk); #1;
    if (!hold) valid_r[sel] = 1'b0;
  endtask

  // Reference frame built from the bit list, then compared cycle by cycle over the whole
  // frame plus the following IDLE cycle. Call right after the accepting posedge.
  task automatic check_frame(input int sel, input logic [8:0] d, input string nm,
                             output logic pbit);
    int dw, cpb, pe, len, b;
    logic [8:0]   m;
    logic         ep, v;
    logic [255:0] o [7];
    logic [255:0] e [7];
    string        vn [7];
    dw  = DW[sel];
    cpb = CPB[sel];
    pe  = (PM[sel] == 1 || PM[sel] == 2) ? 1 : 0;
    len = (1 + dw + pe + SB[sel]) * cpb;
    m   = d & ((9'h1 << dw) - 9'h1);
    ep  = ^m;
    if (PM[sel] == 2) ep = ~ep;
    vn = '{"tx", "busy", "start", "datastate", "parity", "frame_done", "tx_ready"};
    for (int k = 0; k < 7; k++) begin
      o[k] = '0;
      e[k] = '0;
    end
    for (int c = 0; c < len; c++) begin
      b = c / cpb;
      if (b == 0)                    v = 1'b0;
      else if (b <= dw)              v = m[b-1];
      else if (pe == 1 && b == dw+1) v = ep;
      else                           v = 1'b1;
      e[0][c] = v;
      e[1][c] = 1'b1;
      e[2][c] = (b == 0);
      e[3][c] = (b >= 1 && b <= dw);
      e[4][c] = (pe == 1 && b == dw + 1);
    end
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      o[0][c] = tx_s[sel];
      o[1][c] = busy_s[sel];
      o[2][c] = st_s[sel];
      o[3][c] = dat_s[sel];
      o[4][c] = par_s[sel];
      o[5][c] = fd_s[sel];
      o[6][c] = rdy_s[sel];
    end
    pbit = o[0][(dw + 1) * cpb + cpb / 2];
    for (int k = 0; k < 7; k++) begin
      n_tests++;
      if (o[k] !== e[k]) begin
        n_fail++;
        $display("FAIL %s.%s dut%0d word=%h got=%h exp=%h", nm, vn[k], sel, m, o[k], e[k]);
      end
    end
    @(negedge clk);
    n_tests++;
    if ({tx_s[sel], busy_s[sel], rdy_s[sel], fd_s[sel]} !== 4'b1011) begin
      n_fail++;
      $display("FAIL %s.end_cycle dut%0d {tx,busy,rdy,done} got=%b exp=1011", nm, sel,
               {tx_s[sel], busy_s[sel], rdy_s[sel], fd_s[sel]});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int s = 0; s < 3; s++) begin
      valid_r[s] = 1'b0;
      data_r[s]  = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      n_tests++;
      if ({tx_s[s], busy_s[s], rdy_s[s], fd_s[s], st_s[s], dat_s[s], par_s[s]} !== 7'b1010000) begin
        n_fail++;
        $display("FAIL reset dut%0d {tx,busy,rdy,done,start,data,par} got=%b exp=1010000", s,
                 {tx_s[s], busy_s[s], rdy_s[s], fd_s[s], st_s[s], dat_s[s], par_s[s]});
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_default_frame();
    logic pb;
    send_start(0, 9'h0A5, 1'b0);
    check_frame(0, 9'h0A5, "a5_even", pb);
    n_tests++;
    if (pb !== 1'b0) begin
      n_fail++;
      $display("FAIL a5_parity_bit got=%b exp=0", pb);
    end
  endtask

  task automatic test_parity_modes();
    logic pb;
    send_start(1, 9'h001, 1'b0);
    check_frame(1, 9'h001, "odd_01", pb);
    n_tests++;
    if (pb !== 1'b0) begin
      n_fail++;
      $display("FAIL odd_01_parity_bit got=%b exp=0", pb);
    end
    send_start(0, 9'h001, 1'b0);
    check_frame(0, 9'h001, "even_01", pb);
    n_tests++;
    if (pb !== 1'b1) begin
      n_fail++;
      $display("FAIL even_01_parity_bit got=%b exp=1", pb);
    end
  endtask

  task automatic test_nopar_two_stop();
    logic pb;
    send_start(2, 9'h07F, 1'b0);
    check_frame(2, 9'h07F, "w7_7f", pb);
  endtask

  task automatic test_random_words();
    logic       pb;
    int         sel;
    logic [8:0] d;
    for (int i = 0; i < 6; i++) begin
      sel = $urandom_range(0, 2);
      d   = 9'($urandom_range(0, 511));
      send_start(sel, d, 1'b0);
      check_frame(sel, d, "random", pb);
    end
  endtask

  task automatic test_back_to_back();
    logic pb;
    send_start(0, 9'h03C, 1'b1);
    data_r[0] = 9'h0C3;
    check_frame(0, 9'h03C, "b2b_first", pb);
    // valid is still high, so the posedge ending the idle cycle takes 0xC3.
    @(posedge clk); #1;
    valid_r[0] = 1'b0;
    check_frame(0, 9'h0C3, "b2b_second", pb);
  endtask

  task automatic test_reset_mid_frame();
    logic       pb;
    int         fd_cnt, tx_low;
    logic [8:0] d;
    send_start(0, 9'h05A, 1'b0);
    repeat (50) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({tx_s[0], busy_s[0], rdy_s[0], fd_s[0]} !== 4'b1010) begin
      n_fail++;
      $display("FAIL reset_mid {tx,busy,rdy,done} got=%b exp=1010",
               {tx_s[0], busy_s[0], rdy_s[0], fd_s[0]});
    end
    reset  = 1'b0;
    fd_cnt = 0;
    tx_low = 0;
    repeat (200) begin
      @(negedge clk);
      if (fd_s[0] !== 1'b0) fd_cnt++;
      if (tx_s[0] !== 1'b1) tx_low++;
    end
    n_tests++;
    if (fd_cnt != 0 || tx_low != 0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet done_cycles=%0d tx_low_cycles=%0d exp 0 and 0", fd_cnt, tx_low);
    end
    d = 9'($urandom_range(0, 255));
    send_start(0, d, 1'b0);
    check_frame(0, d, "after_reset", pb);
  endtask

  task automatic test_ignore_while_busy();
    logic       pb;
    logic [8:0] d;
    int         len;
    d   = 9'($urandom_range(0, 255));
    len = (1 + DW[1] + 1 + SB[1]) * CPB[1];
    send_start(1, d, 1'b0);
    fork
      check_frame(1, d, "busy_toggle", pb);
      begin
        repeat (len - 2) begin
          @(posedge clk); #1;
          valid_r[1] = 1'($urandom_range(0, 1));
          data_r[1]  = 9'($urandom_range(0, 511));
        end
        valid_r[1] = 1'b0;
      end
    join
  endtask

  initial begin
    test_reset();
    test_default_frame();
    test_parity_modes();
    test_nopar_two_stop();
    test_random_words();
    test_back_to_back();
    test_reset_mid_frame();
    test_ignore_while_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
